scan_decoder: RTL and testbench

- Parametrised, registered successor to the 3-to-8 '138-style decoder: SEL_W-bit select to 2^SEL_W active-low outputs, gated by the G / G2A_N / G2B_N enable triplet.
- Adds a scan mode: an internal prescaler and channel counter step through channels 0..NUM_CH-1 autonomously.
- Drives digit/anode selects for multiplexed displays and bank selects in lab datapaths.

---
 rtl/scan_decoder_if.sv | 24 ++
 rtl/scan_decoder.sv | 88 ++++++++
 tb/tb_scan_decoder.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/scan_decoder_if.sv
// Signal bundle for scan_decoder: the '138-style enable triplet, mode/select
// inputs and the registered decoder outputs.
interface scan_decoder_if #(
    parameter int SEL_W = 3
);
    logic                    g;
    logic                    g2a_n;
    logic                    g2b_n;
    logic                    mode;
    logic [SEL_W-1:0]        sel_in;
    logic [(1<<SEL_W)-1:0]   y;
    logic [SEL_W-1:0]        sel_out;
    logic                    wrap;

    modport master (
        output g, g2a_n, g2b_n, mode, sel_in,
        input  y, sel_out, wrap
    );

    modport slave (
        input  g, g2a_n, g2b_n, mode, sel_in,
        output y, sel_out, wrap
    );
endinterface

// File: rtl/scan_decoder.sv
// Registered SEL_W-to-2^SEL_W active-low decoder with an autonomous scan mode.
// Define SCAN_DECODER_BLANK_EN to blank y during the last clock of each scan slot.
module scan_decoder #(
    parameter int SEL_W  = 3,
    parameter int NUM_CH = 8,
    parameter int DIV    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    scan_decoder_if.slave bus
);
    localparam int OUT_W = 1 << SEL_W;
    localparam int PW    = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
    localparam logic [OUT_W-1:0] ONE_HOT0 = OUT_W'(1);

    logic [OUT_W-1:0] y_q, y_d;
    logic [SEL_W-1:0] sel_out_q, sel_out_d;
    logic             wrap_q, wrap_d;
    logic [PW-1:0]    presc_q, presc_d;

    logic             en;
    logic             blank;
    logic [SEL_W-1:0] scan_cur;

    always_comb begin
        presc_d   = presc_q;
        sel_out_d = sel_out_q;
        y_d       = '1;
        wrap_d    = 1'b0;
        blank     = 1'b0;
        scan_cur  = '0;
        en        = bus.g & ~bus.g2a_n & ~bus.g2b_n;

        if (!en) begin
            // Disabled: counters freeze so a scan resumes mid-slot later.
            presc_d   = presc_q;
            sel_out_d = sel_out_q;
        end else if (!bus.mode) begin
            presc_d   = '0;
            sel_out_d = bus.sel_in;
            if (bus.sel_in <= LAST_CH) begin
                y_d = ~(ONE_HOT0 << bus.sel_in);
            end
        end else begin
            // An out-of-range channel left over from direct mode restarts at 0.
            scan_cur = (sel_out_q > LAST_CH) ? '0 : sel_out_q;
            if (presc_q == PRE_LAST) begin
                presc_d = '0;
                if (scan_cur == LAST_CH) begin
                    sel_out_d = '0;
                    wrap_d    = 1'b1;
                end else begin
                    sel_out_d = scan_cur + SEL_W'(1);
                end
            end else begin
                presc_d   = presc_q + PW'(1);
                sel_out_d = scan_cur;
            end
`ifdef SCAN_DECODER_BLANK_EN
            blank = (presc_d == PRE_LAST);
`else
            blank = 1'b0;
`endif
            y_d = blank ? '1 : ~(ONE_HOT0 << sel_out_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q       <= '1;
            sel_out_q <= '0;
            wrap_q    <= 1'b0;
            presc_q   <= '0;
        end else begin
            y_q       <= y_d;
            sel_out_q <= sel_out_d;
            wrap_q    <= wrap_d;
            presc_q   <= presc_d;
        end
    end

    assign bus.y       = y_q;
    assign bus.sel_out = sel_out_q;
    assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Scoreboard bench for scan_decoder: an 8-channel and a 5-channel instance,
// expectations queued when stimulus is driven and checked after the next edge.
module tb_scan_decoder;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    scan_decoder_if #(.SEL_W(3)) bus_a ();
    scan_decoder_if #(.SEL_W(3)) bus_b ();

    scan_decoder #(.SEL_W(3), .NUM_CH(8), .DIV(DIV)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    scan_decoder #(.SEL_W(3), .NUM_CH(5), .DIV(DIV)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    typedef struct {
        int         inst;
        logic [7:0] y;
        logic [2:0] sel;
        logic       wrap;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    total = 0;
    int    bad   = 0;

    logic [7:0] dir_tab [8];

    task automatic expect_out(input int inst, input string tag,
                              input logic [7:0] y, input logic [2:0] sel, input logic wrap);
        exp_t e;
        e.inst = inst;
        e.y    = y;
        e.sel  = sel;
        e.wrap = wrap;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Expected outputs after the n-th enabled scan edge, counting from a slot start at channel base.
    task automatic expect_scan(input int inst, input string tag, input int n,
                               input int base, input int nch);
        int   ch;
        logic blank;
        logic wr;
        ch    = (base + n / DIV) % nch;
        blank = 1'b0;
`ifdef SCAN_DECODER_BLANK_EN
        blank = ((n % DIV) == DIV - 1);
`endif
        wr = (base == 0) && ((n % (DIV * nch)) == 0);
        expect_out(inst, tag, blank ? 8'hFF : ~(8'h01 << ch), 3'(ch), wr);
    endtask

    task automatic tick();
        exp_t       e;
        string      t;
        logic [7:0] oy;
        logic [2:0] os;
        logic       ow;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (e.inst == 0) begin
                oy = bus_a.y; os = bus_a.sel_out; ow = bus_a.wrap;
            end else begin
                oy = bus_b.y; os = bus_b.sel_out; ow = bus_b.wrap;
            end
            total++;
            assert (oy === e.y) else begin
                bad++;
                $error("FAIL %s y: observed=%h expected=%h", t, oy, e.y);
            end
            total++;
            assert (os === e.sel) else begin
                bad++;
                $error("FAIL %s sel_out: observed=%0d expected=%0d", t, os, e.sel);
            end
            total++;
            assert (ow === e.wrap) else begin
                bad++;
                $error("FAIL %s wrap: observed=%b expected=%b", t, ow, e.wrap);
            end
        end
    endtask

    initial begin
        dir_tab = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

        rst_n = 1'b0;
        bus_a.g = 1'b1; bus_a.g2a_n = 1'b0; bus_a.g2b_n = 1'b0; bus_a.mode = 1'b1; bus_a.sel_in = 3'd0;
        bus_b.g = 1'b0; bus_b.g2a_n = 1'b0; bus_b.g2b_n = 1'b0; bus_b.mode = 1'b0; bus_b.sel_in = 3'd0;
        #2;

        // Reset held for two edges
        for (int i = 0; i < 2; i++) begin
            expect_out(0, $sformatf("reset_a%0d", i), 8'hFF, 3'd0, 1'b0);
            expect_out(1, $sformatf("reset_b%0d", i), 8'hFF, 3'd0, 1'b0);
            tick();
        end

        // Direct decode 0..7
        rst_n = 1'b1;
        bus_a.mode = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus_a.sel_in = 3'(i);
            expect_out(0, $sformatf("direct%0d", i), dir_tab[i], 3'(i), 1'b0);
            tick();
        end

        // Enable gating
        bus_a.sel_in = 3'd3;
        expect_out(0, "gate_on", 8'hF7, 3'd3, 1'b0);
        tick();
        bus_a.g = 1'b0;
        expect_out(0, "gate_g", 8'hFF, 3'd3, 1'b0);
        tick();
        bus_a.g = 1'b1; bus_a.g2a_n = 1'b1;
        expect_out(0, "gate_g2a", 8'hFF, 3'd3, 1'b0);
        tick();
        bus_a.g2a_n = 1'b0; bus_a.g2b_n = 1'b1;
        expect_out(0, "gate_g2b", 8'hFF, 3'd3, 1'b0);
        tick();
        bus_a.g2b_n = 1'b0;
        expect_out(0, "gate_restore", 8'hF7, 3'd3, 1'b0);
        tick();

        // Scan from reset, through two wraps, up to channel 5
        rst_n = 1'b0;
        bus_a.mode = 1'b1;
        expect_out(0, "scan_rst", 8'hFF, 3'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int n = 1; n <= 86; n++) begin
            expect_scan(0, $sformatf("scanA n=%0d", n), n, 0, 8);
            tick();
        end

        // Reset mid-scan at channel 5
        rst_n = 1'b0;
        expect_out(0, "midscan_rst", 8'hFF, 3'd0, 1'b0);
        tick();
        rst_n = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            expect_scan(0, $sformatf("after_rst n=%0d", n), n, 0, 8);
            tick();
        end

        // Scan -> direct -> scan continues from the direct channel
        bus_a.mode = 1'b0; bus_a.sel_in = 3'd2;
        expect_out(0, "to_direct", 8'hFB, 3'd2, 1'b0);
        tick();
        bus_a.mode = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            expect_scan(0, $sformatf("rescan n=%0d", n), n, 2, 8);
            tick();
        end

        // NUM_CH=5 instance: out-of-range direct select
        bus_a.g = 1'b0;
        bus_b.g = 1'b1; bus_b.mode = 1'b0; bus_b.sel_in = 3'd6;
        expect_out(1, "b_direct6", 8'hFF, 3'd6, 1'b0);
        tick();

        // Switch to scan: channel forced to 0
        bus_b.mode = 1'b1;
        for (int n = 1; n <= 13; n++) begin
            expect_scan(1, $sformatf("scanB n=%0d", n), n, 0, 5);
            tick();
        end

        // Disabled mid-slot for three clocks
        bus_b.g = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_out(1, $sformatf("b_hold%0d", i), 8'hFF, 3'd3, 1'b0);
            tick();
        end
        bus_b.g = 1'b1;
        for (int n = 14; n <= 45; n++) begin
            expect_scan(1, $sformatf("scanB n=%0d", n), n, 0, 5);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
